vpu_exec_ctrl: RTL and testbench
================================

Name: vpu_exec_ctrl

Overview:
- Sequencer in front of the VPU execution unit (lanes plus reduction unit).
- Per instruction: accepts one request, fetches up to SRC_CNT source operands from the vector register file one at a time, pulses start to the exec unit, waits for done, then writes the result back through a valid/ready port.
- One instruction in flight. Includes a watchdog that aborts a hung exec operation.

Parameters:
- DWIDTH, 256: operand/result width (DWIDTH_PER_EXEC).
- SRC_CNT, 3: max source operands.
- ADDR_W, 5: register file address width.
- OP_W, 8: width of the packed op_func word.
- TIMEOUT, 255: max WAIT cycles before abort; must be ≥1.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset, synchronous, active-low.
- req_valid_i, input, 1: instruction request valid.
- req_ready_o, output, 1: controller can accept a request.
- req_op_i, input, OP_W: op_func for the exec unit.
- req_src_cnt_i, input, $clog2(SRC_CNT+1): number of sources, 0..SRC_CNT.
- req_src_addr_i, input, SRC_CNT*ADDR_W: source addresses; slot i at [i*ADDR_W+:ADDR_W].
- req_dst_addr_i, input, ADDR_W: destination address.
- rf_rd_en_o, output, 1: register file read request.
- rf_rd_addr_o, output, ADDR_W: read address.
- rf_rd_valid_i, input, 1: read data valid.
- rf_rd_data_i, input, DWIDTH: read data.
- exec_start_o, output, 1: one-cycle start pulse to exec unit.
- exec_op_o, output, OP_W: latched op_func.
- exec_operand_o, output, SRC_CNT*DWIDTH: latched operands; slot i at [i*DWIDTH+:DWIDTH].
- exec_operand_valid_o, output, SRC_CNT: bit i set once slot i is fetched.
- exec_done_i, input, 1: exec unit done.
- exec_dout_i, input, DWIDTH: exec result.
- wb_valid_o, output, 1: writeback valid.
- wb_ready_i, input, 1: writeback accepted.
- wb_addr_o, output, ADDR_W: destination address.
- wb_data_o, output, DWIDTH: result.
- busy_o, output, 1: state ≠ IDLE.
- timeout_err_o, output, 1: one-cycle pulse on watchdog abort.

Behaviour:
- **States:** IDLE, FETCH, FETCH_WAIT, ISSUE, WAIT, WB.
- **Reset:** from any state, including mid-operation, returns to IDLE. All outputs 0, all latched registers 0, operand_valid cleared. No writeback is emitted for an aborted instruction.
- **IDLE:**
  - req_ready_o=1 only in IDLE.
  - On req_valid_i&&req_ready_o: latch op, src_cnt, addresses; clear exec_operand_valid_o; idx=0.
  - Next state is FETCH if src_cnt>0, else ISSUE.
  - src_cnt>SRC_CNT is clamped to SRC_CNT.
- **FETCH:**
  - rf_rd_en_o=1 for exactly one cycle, with rf_rd_addr_o = src_addr[idx].
  - Next state FETCH_WAIT.
- **FETCH_WAIT:**
  - rf_rd_en_o=0. Wait for rf_rd_valid_i (minimum read latency 1 cycle; unbounded wait).
  - On valid: capture data into slot idx and set operand_valid[idx].
  - If idx+1==src_cnt, go to ISSUE; else idx++ and go to FETCH.
  - rf_rd_valid_i is ignored in all other states.
- **ISSUE:**
  - exec_start_o=1 for one cycle; next state WAIT.
  - exec_op_o, exec_operand_o and exec_operand_valid_o are held stable from ISSUE through the end of WB.
  - Unused slots stay 0/invalid.
- **WAIT:**
  - exec_done_i is sampled only here. Done in the ISSUE cycle or earlier is ignored.
  - On done: capture exec_dout_i into wb_data, then go to WB.
  - Watchdog: wcnt clears on entry and increments each WAIT cycle without done.
  - If wcnt reaches TIMEOUT with no done: timeout_err_o=1 for one cycle, go to IDLE, no WB.
  - If done and timeout coincide, done wins.
- **WB:**
  - wb_valid_o=1, with wb_addr_o/wb_data_o stable until wb_ready_i.
  - On wb_valid_o&&wb_ready_i: go to IDLE. A new request can be accepted on the following cycle; no same-cycle bypass.
- **Throughput and latency:**
  - Accept-to-start latency is 1 + Σ(1+Lrd_i) cycles, where Lrd is read latency.
  - With src_cnt=0, exec_start_o is asserted the cycle after accept.

Test Plan:
- **Two-source, no stall:** src_cnt=2, addrs 3,7, Lrd=1, exec done 4 cycles after start, wb_ready=1.
  - Expect rd_en at cycles 1 (addr 3) and 3 (addr 7).
  - Expect start at cycle 5, operand_valid=3'b011.
  - Expect wb_valid at cycle 10 with data=exec_dout.
- **Zero sources:** src_cnt=0, accept at cycle 0.
  - Expect start at cycle 1, no rd_en, operand_valid=0.
- **Read and writeback stalls:** rd_valid delayed 5 cycles; wb_ready low 3 cycles.
  - Expect rd_en to pulse once per operand.
  - Expect wb_valid/addr/data stable for 3 cycles; req_ready stays 0 until after the handshake.
- **Watchdog:** TIMEOUT=8 with exec_done never asserted.
  - Expect timeout_err one-cycle pulse after 8 WAIT cycles, return to IDLE, wb_valid never high.
  - Repeat with done on the 8th WAIT cycle: expect writeback and no error.
- **Stray inputs:** exec_done asserted during ISSUE and rf_rd_valid asserted in IDLE.
  - Expect both ignored; controller still waits for a real done.
- **Mid-operation reset:** rst_n low for one cycle in FETCH_WAIT, WAIT and WB in turn.
  - Expect all outputs 0 the next cycle, req_ready=1 after release, and no spurious wb_valid.

Source files
------------

// File: rtl/vpu_exec_ctrl.sv
// VPU execution sequencer: fetches source operands from the register file,
// starts the exec unit, guards it with a watchdog and writes the result back.
module vpu_exec_ctrl #(
   parameter int DWIDTH  = 256,
   parameter int SRC_CNT = 3,
   parameter int ADDR_W  = 5,
   parameter int OP_W    = 8,
   parameter int TIMEOUT = 255
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           req_valid_i,
   output logic                           req_ready_o,
   input  logic [OP_W-1:0]                req_op_i,
   input  logic [$clog2(SRC_CNT+1)-1:0]   req_src_cnt_i,
   input  logic [SRC_CNT*ADDR_W-1:0]      req_src_addr_i,
   input  logic [ADDR_W-1:0]              req_dst_addr_i,
   output logic                           rf_rd_en_o,
   output logic [ADDR_W-1:0]              rf_rd_addr_o,
   input  logic                           rf_rd_valid_i,
   input  logic [DWIDTH-1:0]              rf_rd_data_i,
   output logic                           exec_start_o,
   output logic [OP_W-1:0]                exec_op_o,
   output logic [SRC_CNT*DWIDTH-1:0]      exec_operand_o,
   output logic [SRC_CNT-1:0]             exec_operand_valid_o,
   input  logic                           exec_done_i,
   input  logic [DWIDTH-1:0]              exec_dout_i,
   output logic                           wb_valid_o,
   input  logic                           wb_ready_i,
   output logic [ADDR_W-1:0]              wb_addr_o,
   output logic [DWIDTH-1:0]              wb_data_o,
   output logic                           busy_o,
   output logic                           timeout_err_o
);

   localparam int CW = $clog2(SRC_CNT+1);
   localparam int WW = $clog2(TIMEOUT+1);
   localparam logic [CW-1:0] CMAX = CW'(SRC_CNT);
   localparam logic [WW-1:0] WLIM = WW'(TIMEOUT-1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_FETCH_WAIT,
      S_ISSUE,
      S_WAIT,
      S_WB
   } state_e;

   state_e                      state_q;
   logic [CW-1:0]               cnt_q;
   logic [CW-1:0]               idx_q;
   logic [SRC_CNT*ADDR_W-1:0]   addr_q;
   logic [ADDR_W-1:0]           dst_q;
   logic [OP_W-1:0]             op_q;
   logic [SRC_CNT*DWIDTH-1:0]   opnd_q;
   logic [SRC_CNT-1:0]          opv_q;
   logic [WW-1:0]               wcnt_q;
   logic [DWIDTH-1:0]           wdat_q;
   logic                        rd_en_q;
   logic [ADDR_W-1:0]           rd_addr_q;
   logic                        start_q;
   logic                        wbv_q;
   logic                        tmo_q;
   logic [CW-1:0]               cnt_d;
   logic [CW-1:0]               idx_d;

   // Clamp the requested source count and precompute the next slot index
   always_comb begin
      cnt_d = req_src_cnt_i;
      if (int'(req_src_cnt_i) > SRC_CNT) cnt_d = CMAX;
      idx_d = idx_q + CW'(1);
   end

   // Sequencer FSM with registered handshake and strobe outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         addr_q    <= '0;
         dst_q     <= '0;
         op_q      <= '0;
         opnd_q    <= '0;
         opv_q     <= '0;
         wcnt_q    <= '0;
         wdat_q    <= '0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         start_q   <= 1'b0;
         wbv_q     <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         rd_en_q <= 1'b0;
         start_q <= 1'b0;
         tmo_q   <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (req_valid_i) begin
                  op_q   <= req_op_i;
                  cnt_q  <= cnt_d;
                  addr_q <= req_src_addr_i;
                  dst_q  <= req_dst_addr_i;
                  opnd_q <= '0;
                  opv_q  <= '0;
                  idx_q  <= '0;
                  if (cnt_d != '0) begin
                     state_q   <= S_FETCH;
                     rd_en_q   <= 1'b1;
                     rd_addr_q <= req_src_addr_i[ADDR_W-1:0];
                  end else begin
                     state_q <= S_ISSUE;
                     start_q <= 1'b1;
                  end
               end
            end
            S_FETCH: state_q <= S_FETCH_WAIT;
            S_FETCH_WAIT: begin
               if (rf_rd_valid_i) begin
                  opnd_q[int'(idx_q)*DWIDTH +: DWIDTH] <= rf_rd_data_i;
                  opv_q[idx_q] <= 1'b1;
                  if (idx_d == cnt_q) begin
                     state_q <= S_ISSUE;
                     start_q <= 1'b1;
                  end else begin
                     idx_q     <= idx_d;
                     state_q   <= S_FETCH;
                     rd_en_q   <= 1'b1;
                     rd_addr_q <= addr_q[int'(idx_d)*ADDR_W +: ADDR_W];
                  end
               end
            end
            S_ISSUE: begin
               wcnt_q  <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (exec_done_i) begin
                  wdat_q  <= exec_dout_i;
                  wbv_q   <= 1'b1;
                  state_q <= S_WB;
               end else if (wcnt_q == WLIM) begin
                  tmo_q   <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  wcnt_q <= wcnt_q + WW'(1);
               end
            end
            S_WB: begin
               if (wb_ready_i) begin
                  wbv_q   <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready_o          = (state_q == S_IDLE);
   assign busy_o               = (state_q != S_IDLE);
   assign rf_rd_en_o           = rd_en_q;
   assign rf_rd_addr_o         = rd_addr_q;
   assign exec_start_o         = start_q;
   assign exec_op_o            = op_q;
   assign exec_operand_o       = opnd_q;
   assign exec_operand_valid_o = opv_q;
   assign wb_valid_o           = wbv_q;
   assign wb_addr_o            = dst_q;
   assign wb_data_o            = wdat_q;
   assign timeout_err_o        = tmo_q;

endmodule

// File: tb/tb_vpu_exec_ctrl.sv
// Bench for vpu_exec_ctrl: directed scenarios plus random instructions
// checked against a cycle-count and register-file reference model.
module tb_vpu_exec_ctrl;

   localparam int DW  = 64;
   localparam int SC  = 3;
   localparam int AW  = 5;
   localparam int OW  = 8;
   localparam int TMO = 8;

   logic              clk;
   logic              rst_n;
   logic              req_valid_i;
   logic              req_ready_o;
   logic [OW-1:0]     req_op_i;
   logic [1:0]        req_src_cnt_i;
   logic [SC*AW-1:0]  req_src_addr_i;
   logic [AW-1:0]     req_dst_addr_i;
   logic              rf_rd_en_o;
   logic [AW-1:0]     rf_rd_addr_o;
   logic              rf_rd_valid_i;
   logic [DW-1:0]     rf_rd_data_i;
   logic              exec_start_o;
   logic [OW-1:0]     exec_op_o;
   logic [SC*DW-1:0]  exec_operand_o;
   logic [SC-1:0]     exec_operand_valid_o;
   logic              exec_done_i;
   logic [DW-1:0]     exec_dout_i;
   logic              wb_valid_o;
   logic              wb_ready_i;
   logic [AW-1:0]     wb_addr_o;
   logic [DW-1:0]     wb_data_o;
   logic              busy_o;
   logic              timeout_err_o;

   int checks;
   int errors;
   logic [DW-1:0] rf [32];

   vpu_exec_ctrl #(
      .DWIDTH (DW),
      .SRC_CNT(SC),
      .ADDR_W (AW),
      .OP_W   (OW),
      .TIMEOUT(TMO)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .req_valid_i         (req_valid_i),
      .req_ready_o         (req_ready_o),
      .req_op_i            (req_op_i),
      .req_src_cnt_i       (req_src_cnt_i),
      .req_src_addr_i      (req_src_addr_i),
      .req_dst_addr_i      (req_dst_addr_i),
      .rf_rd_en_o          (rf_rd_en_o),
      .rf_rd_addr_o        (rf_rd_addr_o),
      .rf_rd_valid_i       (rf_rd_valid_i),
      .rf_rd_data_i        (rf_rd_data_i),
      .exec_start_o        (exec_start_o),
      .exec_op_o           (exec_op_o),
      .exec_operand_o      (exec_operand_o),
      .exec_operand_valid_o(exec_operand_valid_o),
      .exec_done_i         (exec_done_i),
      .exec_dout_i         (exec_dout_i),
      .wb_valid_o          (wb_valid_o),
      .wb_ready_i          (wb_ready_i),
      .wb_addr_o           (wb_addr_o),
      .wb_data_o           (wb_data_o),
      .busy_o              (busy_o),
      .timeout_err_o       (timeout_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] r64();
      return {$urandom, $urandom};
   endfunction

   task automatic chk(input string tag,
                      input logic [SC*DW-1:0] obs,
                      input logic [SC*DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rd_en"}, rf_rd_en_o, 0);
      chk({tag, "_rd_addr"}, rf_rd_addr_o, 0);
      chk({tag, "_start"}, exec_start_o, 0);
      chk({tag, "_op"}, exec_op_o, 0);
      chk({tag, "_opnd"}, exec_operand_o, 0);
      chk({tag, "_opv"}, exec_operand_valid_o, 0);
      chk({tag, "_wbv"}, wb_valid_o, 0);
      chk({tag, "_wba"}, wb_addr_o, 0);
      chk({tag, "_wbd"}, wb_data_o, 0);
      chk({tag, "_tmo"}, timeout_err_o, 0);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_ready"}, req_ready_o, 1);
   endtask

   // One complete instruction; done_k is the WAIT cycle (1-based) that
   // sees done, values outside 1..TMO mean the exec unit never answers.
   task automatic run_txn(input logic [OW-1:0] op, input int cnt,
                          input int a0, input int a1, input int a2,
                          input int dst,
                          input int l0, input int l1, input int l2,
                          input int done_k, input int stall,
                          input bit stray);
      int a[3];
      int l[3];
      logic [DW-1:0] res;
      logic [SC*DW-1:0] eopnd;
      logic [SC-1:0] emask;
      bit to;
      bit fired;
      a[0] = a0; a[1] = a1; a[2] = a2;
      l[0] = l0; l[1] = l1; l[2] = l2;
      eopnd = '0;
      emask = '0;
      for (int i = 0; i < cnt; i++) begin
         eopnd[i*DW +: DW] = rf[a[i]];
         emask[i] = 1'b1;
      end
      to = !(done_k >= 1 && done_k <= TMO);
      res = r64();

      chk("idle_ready", req_ready_o, 1);
      if (stray) begin
         rf_rd_valid_i = 1'b1;
         rf_rd_data_i  = r64();
         tick();
         rf_rd_valid_i = 1'b0;
         chk("stray_rd_busy", busy_o, 0);
      end
      req_valid_i    = 1'b1;
      req_op_i       = op;
      req_src_cnt_i  = 2'(cnt);
      req_src_addr_i = {5'(a2), 5'(a1), 5'(a0)};
      req_dst_addr_i = 5'(dst);
      tick();
      req_valid_i    = 1'b0;
      req_op_i       = 8'($urandom);
      req_src_addr_i = 15'($urandom);
      req_dst_addr_i = 5'($urandom);
      chk("acc_busy", busy_o, 1);
      chk("acc_ready", req_ready_o, 0);

      for (int i = 0; i < cnt; i++) begin
         chk("fetch_rd_en", rf_rd_en_o, 1);
         chk("fetch_addr", rf_rd_addr_o, a[i]);
         chk("fetch_nostart", exec_start_o, 0);
         tick();
         for (int w = 1; w < l[i]; w++) begin
            chk("fwait_rd_en", rf_rd_en_o, 0);
            rf_rd_data_i = r64();
            tick();
         end
         chk("fwait_rd_en", rf_rd_en_o, 0);
         rf_rd_valid_i = 1'b1;
         rf_rd_data_i  = rf[a[i]];
         tick();
         rf_rd_valid_i = 1'b0;
         rf_rd_data_i  = r64();
      end

      chk("issue_start", exec_start_o, 1);
      chk("issue_rd_en", rf_rd_en_o, 0);
      chk("issue_op", exec_op_o, op);
      chk("issue_opnd", exec_operand_o, eopnd);
      chk("issue_opv", exec_operand_valid_o, emask);
      if (stray) begin
         exec_done_i = 1'b1;
         exec_dout_i = r64();
      end
      tick();
      exec_done_i = 1'b0;

      fired = 1'b0;
      for (int k = 1; k <= TMO && !fired; k++) begin
         chk("wait_start", exec_start_o, 0);
         chk("wait_wbv", wb_valid_o, 0);
         chk("wait_tmo", timeout_err_o, 0);
         chk("wait_busy", busy_o, 1);
         exec_done_i = (k == done_k);
         exec_dout_i = (k == done_k) ? res : r64();
         tick();
         exec_done_i = 1'b0;
         if (k == done_k) fired = 1'b1;
      end

      if (!to) begin
         chk("wb_valid", wb_valid_o, 1);
         chk("wb_addr", wb_addr_o, dst);
         chk("wb_data", wb_data_o, res);
         chk("wb_tmo", timeout_err_o, 0);
         chk("wb_ready", req_ready_o, 0);
         chk("wb_op_hold", exec_op_o, op);
         chk("wb_opnd_hold", exec_operand_o, eopnd);
         chk("wb_opv_hold", exec_operand_valid_o, emask);
         for (int s = 0; s < stall; s++) begin
            wb_ready_i = 1'b0;
            tick();
            chk("stall_wbv", wb_valid_o, 1);
            chk("stall_addr", wb_addr_o, dst);
            chk("stall_data", wb_data_o, res);
            chk("stall_ready", req_ready_o, 0);
         end
         wb_ready_i = 1'b1;
         tick();
         wb_ready_i = 1'b0;
         chk("post_wb_valid", wb_valid_o, 0);
         chk("post_wb_ready", req_ready_o, 1);
         chk("post_wb_busy", busy_o, 0);
      end else begin
         chk("tmo_pulse", timeout_err_o, 1);
         chk("tmo_ready", req_ready_o, 1);
         chk("tmo_wbv", wb_valid_o, 0);
         tick();
         chk("tmo_clear", timeout_err_o, 0);
         chk("tmo_wbv2", wb_valid_o, 0);
      end
   endtask

   // Start an instruction, then pull reset in FETCH_WAIT (0), WAIT (1)
   // or WB (2) and confirm the controller comes back clean.
   task automatic run_abort(input int phase);
      req_valid_i    = 1'b1;
      req_op_i       = 8'h5A;
      req_src_cnt_i  = 2'd1;
      req_src_addr_i = 15'd5;
      req_dst_addr_i = 5'd9;
      tick();
      req_valid_i = 1'b0;
      tick();
      if (phase >= 1) begin
         rf_rd_valid_i = 1'b1;
         rf_rd_data_i  = rf[5];
         tick();
         rf_rd_valid_i = 1'b0;
         tick();
         tick();
         chk("abort_in_wait", busy_o, 1);
      end
      if (phase >= 2) begin
         exec_done_i = 1'b1;
         exec_dout_i = r64();
         tick();
         exec_done_i = 1'b0;
         chk("abort_in_wb", wb_valid_o, 1);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk_reset_outputs("abort");
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("abort_no_wb", wb_valid_o, 0);
         chk("abort_idle", busy_o, 0);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 32; i++) rf[i] = r64();
      rst_n          = 1'b0;
      req_valid_i    = 1'b0;
      req_op_i       = '0;
      req_src_cnt_i  = '0;
      req_src_addr_i = '0;
      req_dst_addr_i = '0;
      rf_rd_valid_i  = 1'b0;
      rf_rd_data_i   = '0;
      exec_done_i    = 1'b0;
      exec_dout_i    = '0;
      wb_ready_i     = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      chk_reset_outputs("reset");
      tick();

      run_txn(8'h11, 2, 3, 7, 0, 4, 1, 1, 1, 4, 0, 1'b0);
      run_txn(8'h22, 0, 0, 0, 0, 6, 1, 1, 1, 3, 0, 1'b0);
      run_txn(8'h33, 3, 1, 2, 30, 17, 5, 5, 5, 2, 3, 1'b0);
      run_txn(8'h44, 1, 12, 0, 0, 8, 1, 1, 1, 0, 0, 1'b0);
      run_txn(8'h55, 1, 13, 0, 0, 8, 1, 1, 1, TMO, 0, 1'b0);
      run_txn(8'h66, 2, 20, 21, 0, 31, 2, 1, 1, 5, 1, 1'b1);

      run_abort(0);
      run_abort(1);
      run_abort(2);

      for (int t = 0; t < 40; t++) begin
         run_txn(8'($urandom), $urandom_range(0, 3),
                 $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(1, 4), $urandom_range(1, 4),
                 $urandom_range(1, 4), $urandom_range(1, TMO + 2),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
